mem_access: RTL and testbench

Memory-stage data access unit of the five-stage MIPS pipeline. Sits between the EX/MEM register and the MEM/WB register. Turns a load/store in the M stage into a request/acknowledge transaction on the data-memory port, with byte-lane alignment and sign extension. Stalls the pipeline until the access completes, and delivers the aligned load result as `rdm` to the MEM/WB register.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/load_align.sv | 26 ++
 rtl/mem_access.sv | 119 +++++++++++
 tb/tb_mem_access.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the M-stage data access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } mem_state_t;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane select plus sign/zero extension (little-endian lanes).
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{addr, 3'b000} +: 8];
    h    = addr[1] ? word[31:16] : word[15:0];
    data = word;
    case (size)
      SZ_BYTE: data = {{24{sgn & b[7]}}, b};
      SZ_HALF: data = {{16{sgn & h[15]}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit: req/ack data-memory transaction, lane alignment,
// pipeline stall and bus-error timeout.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memreadm,
  input  logic        memwritem,
  input  logic [1:0]  memsizem,
  input  logic        memsignedm,
  input  logic [31:0] aluoutm,
  input  logic [31:0] writedatam,
  output logic [31:0] rdm,
  output logic        stall,
  output logic        adel,
  output logic        ades,
  output logic        buserr,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [3:0]  dbe,
  output logic [31:0] dwdata,
  input  logic [31:0] drdata,
  input  logic        dack
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  mem_state_t    state;
  logic [CW-1:0] cnt;
  logic          access, misaligned, go;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n, ld_data;

  always_comb begin
    access     = memreadm | memwritem;
    misaligned = 1'b0;
    be_n       = 4'b1111;
    wdata_n    = writedatam;
    case (memsizem)
      SZ_BYTE: begin
        be_n    = 4'b0001 << aluoutm[1:0];
        wdata_n = {4{writedatam[7:0]}};
      end
      SZ_HALF: begin
        misaligned = aluoutm[0];
        be_n       = aluoutm[1] ? 4'b1100 : 4'b0011;
        wdata_n    = {2{writedatam[15:0]}};
      end
      default: misaligned = |aluoutm[1:0];
    endcase
    go    = access & ~misaligned;
    adel  = access & misaligned & memreadm;
    ades  = access & misaligned & ~memreadm;
    stall = (state == REQ) || ((state == IDLE) && go);
  end

  load_align u_load_align (
    .word (drdata),
    .addr (aluoutm[1:0]),
    .size (memsizem),
    .sgn  (memsignedm),
    .data (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rdm    <= '0;
      buserr <= 1'b0;
      dreq   <= 1'b0;
      dwe    <= 1'b0;
      daddr  <= '0;
      dbe    <= '0;
      dwdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          rdm    <= '0;
          buserr <= 1'b0;
          if (go) begin
            state  <= REQ;
            cnt    <= '0;
            dreq   <= 1'b1;
            dwe    <= ~memreadm;
            daddr  <= {aluoutm[31:2], 2'b00};
            dbe    <= be_n;
            dwdata <= wdata_n;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          // dack wins over a timeout landing in the same cycle
          if (dack || (cnt == CW'(TIMEOUT - 1))) begin
            state  <= DONE;
            rdm    <= (dack && memreadm) ? ld_data : '0;
            buserr <= ~dack;
            dreq   <= 1'b0;
            dwe    <= 1'b0;
            daddr  <= '0;
            dbe    <= '0;
            dwdata <= '0;
          end
        end
        DONE: begin
          state  <= IDLE;
          rdm    <= '0;
          buserr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access against a byte-level reference model.
module tb_mem_access;

  localparam int unsigned TO = 4;

  logic        clk, rst_n;
  logic        memreadm, memwritem, memsignedm;
  logic [1:0]  memsizem;
  logic [31:0] aluoutm, writedatam;
  logic [31:0] rdm;
  logic        stall, adel, ades, buserr;
  logic        dreq, dwe;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dbe;
  logic        dack;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .memreadm(memreadm), .memwritem(memwritem), .memsizem(memsizem),
    .memsignedm(memsignedm), .aluoutm(aluoutm), .writedatam(writedatam),
    .rdm(rdm), .stall(stall), .adel(adel), .ades(ades), .buserr(buserr),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dbe(dbe), .dwdata(dwdata),
    .drdata(drdata), .dack(dack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  typedef struct {
    logic [31:0] rdm;
    logic        buserr;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr, input logic [1:0] sz);
    return (addr % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] sz, input logic sgn);
    int unsigned nb;
    logic [31:0] v, mask;
    nb = nbytes(sz);
    v  = word >> (8 * (addr % 4));
    if (nb < 4) begin
      mask = (32'h1 << (8 * nb)) - 32'h1;
      v    = v & mask;
      if (sgn && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] sz);
    logic [3:0] m;
    m = 4'((32'h1 << nbytes(sz)) - 32'h1);
    return m << (addr % 4);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
    return w;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic prev;
    req_t cur;
    rsp_t r;
    prev = 1'b0;
    cur  = '{addr: '0, be: '0, wdata: '0, we: 1'b0};
    forever begin
      @(negedge clk);
      if (!rst_n) prev = 1'b0;
      else begin
        if (dreq && !prev) begin
          if (req_q.size() == 0) begin
            n_checks++;
            $display("FAIL req_unexpected: got dreq=1 expected no request");
          end else begin
            cur = req_q.pop_front();
            check("daddr", daddr, cur.addr);
            check("dbe", {28'h0, dbe}, {28'h0, cur.be});
            check("dwdata", dwdata, cur.wdata);
            check("dwe", {31'h0, dwe}, {31'h0, cur.we});
          end
        end else if (dreq) begin
          check("daddr_hold", daddr, cur.addr);
        end
        if (!dreq && prev) begin
          if (rsp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rsp_unexpected: got completion expected none");
          end else begin
            r = rsp_q.pop_front();
            check("rdm", rdm, r.rdm);
            check("buserr", {31'h0, buserr}, {31'h0, r.buserr});
          end
        end
        prev = dreq;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic clear_inputs();
    memreadm = 0; memwritem = 0; memsizem = 0; memsignedm = 0;
    aluoutm = 0; writedatam = 0;
  endtask

  // lat: REQ cycle index carrying dack; lat >= TO means dack never comes
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int unsigned lat);
    req_t q;
    rsp_t r;
    int unsigned k, stalls, exp_stalls;
    logic timeout;
    @(negedge clk);
    memreadm = rd; memwritem = wr; memsizem = sz; memsignedm = sgn;
    aluoutm = addr; writedatam = wd; dack = 0;
    if (is_misaligned(addr, sz)) begin
      #1;
      check("adel", {31'h0, adel}, {31'h0, rd});
      check("ades", {31'h0, ades}, {31'h0, ~rd});
      check("stall_misaligned", {31'h0, stall}, 32'h0);
      check("rdm_misaligned", rdm, 32'h0);
      repeat (3) begin
        @(negedge clk);
        check("dreq_misaligned", {31'h0, dreq}, 32'h0);
      end
      clear_inputs();
      return;
    end
    timeout = (lat >= TO);
    q = '{addr: {addr[31:2], 2'b00}, be: model_be(addr, sz),
          wdata: model_wdata(wd, sz), we: ~rd};
    r = '{rdm: (rd && !timeout) ? model_load(rdata, addr, sz, sgn) : 32'h0, buserr: timeout};
    req_q.push_back(q);
    rsp_q.push_back(r);
    exp_stalls = timeout ? TO + 1 : lat + 2;
    k = 0; stalls = 0;
    #1;
    while (stall && k < 50) begin
      stalls++;
      if (k == 0) begin
        dack = 1'($urandom_range(0, 1));
        drdata = $urandom;
      end else if (k == lat + 1) begin
        dack = 1; drdata = rdata;
      end else begin
        dack = 0; drdata = $urandom;
      end
      @(negedge clk);
      #1;
      k++;
    end
    check("stall_cycles", stalls, exp_stalls);
    dack = 1'($urandom_range(0, 1));
    drdata = $urandom;
    @(posedge clk);
    #1;
    clear_inputs();
    dack = 0;
  endtask

  initial begin
    logic [31:0] a, w;
    logic [1:0]  sz;
    logic        rd, wr;
    int unsigned kind, lat;
    rst_n = 0; dack = 0; drdata = 0;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("rst_rdm", rdm, 32'h0);
    check("rst_dreq", {31'h0, dreq}, 32'h0);
    check("rst_dwe", {31'h0, dwe}, 32'h0);
    check("rst_dbe", {28'h0, dbe}, 32'h0);
    check("rst_daddr", daddr, 32'h0);
    check("rst_dwdata", dwdata, 32'h0);
    check("rst_buserr", {31'h0, buserr}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_adel_ades", {30'h0, adel, ades}, 32'h0);
    rst_n = 1;

    access(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    access(1, 0, 2'd0, 1, 32'h13, 32'h0, 32'h80FF7F01, 1);
    access(1, 0, 2'd0, 0, 32'h13, 32'h0, 32'h80FF7F01, 2);
    access(0, 1, 2'd1, 0, 32'h22, 32'h0000ABCD, 32'h0, 0);
    access(1, 0, 2'd2, 0, 32'h6, 32'h0, 32'h0, 0);
    access(1, 0, 2'd2, 0, 32'h30, 32'h0, 32'h12345678, 255);
    access(1, 1, 2'd1, 1, 32'h42, 32'h5555AAAA, 32'h8001FFFF, 3);
    access(0, 1, 2'd3, 0, 32'h44, 32'hCAFEF00D, 32'h0, 1);
    @(negedge clk);
    check("idle_rdm", rdm, 32'h0);
    check("idle_stall", {31'h0, stall}, 32'h0);

    // reset asserted mid-REQ
    @(negedge clk);
    memreadm = 1; memsizem = 2'd2; aluoutm = 32'h80;
    req_q.push_back('{addr: 32'h80, be: 4'hF, wdata: 32'h0, we: 1'b0});
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("rst_mid_dreq", {31'h0, dreq}, 32'h0);
    check("rst_mid_rdm", rdm, 32'h0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    dack = 1; drdata = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge clk);
      check("late_dack_rdm", rdm, 32'h0);
      check("late_dack_dreq", {31'h0, dreq}, 32'h0);
      check("late_dack_stall", {31'h0, stall}, 32'h0);
    end
    dack = 0;

    for (int t = 0; t < 60; t++) begin
      sz   = 2'($urandom_range(0, 3));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(nbytes(sz) - 1);
      kind = $urandom_range(0, 2);
      rd   = (kind != 1);
      wr   = (kind != 0);
      w    = $urandom;
      lat  = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 3);
      access(rd, wr, sz, 1'($urandom_range(0, 1)), a, w, $urandom, lat);
    end

    repeat (3) @(negedge clk);
    check("req_q_drained", req_q.size(), 32'h0);
    check("rsp_q_drained", rsp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
